// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: data-memory FSM states, word geometry and the
// LDUR/STUR opcodes also used by the core's decoder.
package legv8_pkg;

  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned WORD_W     = 64;

  localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } dmem_state_e;

  // Encoded as {MEMWRITE, MEMREAD} so the request lines latch directly.
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_BOTH  = 2'b11
  } dmem_op_e;

endpackage

// File: rtl/legv8_dmem_array.sv
// Synchronous single-port 64-bit word RAM; write and read both registered at
// the clock edge (read returns the pre-write contents on a same-edge write).
module legv8_dmem_array
  import legv8_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128
) (
  input  logic                           CLOCK,
  input  logic                           WRITE_EN,
  input  logic [$clog2(DEPTH_WORDS)-1:0] INDEX,
  input  logic [WORD_W-1:0]              WRITE_DATA,
  output logic [WORD_W-1:0]              READ_DATA
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge CLOCK) begin
    if (WRITE_EN) begin
      mem[INDEX] <= WRITE_DATA;
    end
    READ_DATA <= mem[INDEX];
  end

endmodule

// File: rtl/legv8_dmem_responder.sv
// LEGv8 data-memory responder: wait-stated 64-bit load/store with registered
// read return and error reporting. Define LEGV8_DMEM_FWD_EN for store-to-load forwarding.
module legv8_dmem_responder
  import legv8_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              MEMREAD,
  input  logic              MEMWRITE,
  input  logic [63:0]       ADDRESS,
  input  logic [WORD_W-1:0] WRITE_DATA,
  output logic [WORD_W-1:0] READ_DATA,
  output logic              MEM_READY,
  output logic              MEM_ERROR,
  output logic              MEM_BUSY
);

  localparam int unsigned IW      = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN    = 64'(DEPTH_WORDS) * 64'(WORD_BYTES);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [63:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  dmem_op_e          op_q;
  logic [WORD_W-1:0] rdata_q;
  logic              ready_q, err_q;

  logic              req, accept, commit, bad, arr_we, fwd_hit_live;
  logic [63:0]       off_live, off_q;
  logic [IW-1:0]     idx_live, idx_q, arr_idx;
  logic [WORD_W-1:0] arr_rdata, load_data;

  assign req      = MEMREAD | MEMWRITE;
  assign accept   = (state_q == ST_IDLE) && req;
  assign commit   = (state_q == ST_BUSY) && (cnt_q == '0);

  assign off_live = ADDRESS - BASE_ADDR;
  assign off_q    = addr_q - BASE_ADDR;
  assign idx_live = IW'(off_live >> 3);
  assign idx_q    = IW'(off_q >> 3);

  assign bad = (addr_q[2:0] != 3'b000) || (addr_q < BASE_ADDR) ||
               (off_q >= SPAN) || (op_q == OP_BOTH);

  // In IDLE the RAM reads at the live address so the word is already
  // registered when the latched request commits, even with zero wait states.
  assign arr_idx = (state_q == ST_IDLE) ? idx_live : idx_q;
  assign arr_we  = commit && (op_q == OP_STORE) && !bad;

  legv8_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .CLOCK      (CLOCK),
    .WRITE_EN   (arr_we),
    .INDEX      (arr_idx),
    .WRITE_DATA (wdata_q),
    .READ_DATA  (arr_rdata)
  );

`ifdef LEGV8_DMEM_FWD_EN
  logic              fwd_v_q, fwd_hit_q, live_ok;
  logic [IW-1:0]     fwd_idx_q;
  logic [WORD_W-1:0] fwd_data_q;

  assign live_ok = (ADDRESS[2:0] == 3'b000) && (ADDRESS >= BASE_ADDR) && (off_live < SPAN);
  assign fwd_hit_live = MEMREAD && !MEMWRITE && live_ok && fwd_v_q && (idx_live == fwd_idx_q);
  assign load_data = fwd_hit_q ? fwd_data_q : arr_rdata;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      fwd_v_q    <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_idx_q  <= '0;
      fwd_data_q <= '0;
    end else if (accept) begin
      fwd_v_q   <= 1'b0;
      fwd_hit_q <= fwd_hit_live;
    end else if (arr_we) begin
      fwd_v_q    <= 1'b1;
      fwd_idx_q  <= idx_q;
      fwd_data_q <= wdata_q;
    end
  end
`else
  assign fwd_hit_live = 1'b0;
  assign load_data    = arr_rdata;
`endif

  // Every request passes through BUSY at least once; the counter is loaded
  // with the full wait count (zero for a forwarded load), giving WAIT_CYCLES+1
  // edges from accept to the RESP entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_BUSY;
          cnt_d   = fwd_hit_live ? 4'd0 : WAIT_LD;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_NONE;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= ADDRESS;
        wdata_q <= WRITE_DATA;
        op_q    <= dmem_op_e'({MEMWRITE, MEMREAD});
      end
      if (commit) begin
        ready_q <= 1'b1;
        err_q   <= bad;
        if (bad) begin
          rdata_q <= '0;
        end else if (op_q == OP_LOAD) begin
          rdata_q <= load_data;
        end
      end else if (state_q == ST_RESP) begin
        ready_q <= 1'b0;
        err_q   <= 1'b0;
      end
    end
  end

  assign READ_DATA = rdata_q;
  assign MEM_READY = ready_q;
  assign MEM_ERROR = err_q;
  assign MEM_BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_legv8_dmem_responder.sv
// Randomized bench for legv8_dmem_responder against a word-array reference
// model; expected latency follows LEGV8_DMEM_FWD_EN when defined.
module tb_legv8_dmem_responder;

  localparam int unsigned DEPTH = 128;
  localparam logic [63:0] BASE  = 64'h0;
  localparam int unsigned WAITC = 2;
  localparam int unsigned LIMIT = 40;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        MEMREAD, MEMWRITE;
  logic [63:0] ADDRESS, WRITE_DATA, READ_DATA;
  logic        MEM_READY, MEM_ERROR, MEM_BUSY;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [63:0] model_mem [DEPTH];
  logic [63:0] exp_rd;
  bit          tag_v;
  logic [63:0] tag_addr;
  logic [63:0] last_store;

  legv8_dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .MEMREAD    (MEMREAD),
    .MEMWRITE   (MEMWRITE),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .MEM_READY  (MEM_READY),
    .MEM_ERROR  (MEM_ERROR),
    .MEM_BUSY   (MEM_BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input bit rd, input bit wr, input logic [63:0] addr);
    return (addr[2:0] != 3'b000) || (addr < BASE) ||
           ((addr - BASE) >= 64'(DEPTH) * 64'd8) || (rd && wr);
  endfunction

  task automatic idle_inputs();
    MEMREAD    = 1'b0;
    MEMWRITE   = 1'b0;
    ADDRESS    = '0;
    WRITE_DATA = '0;
  endtask

  task automatic garbage_inputs();
    MEMREAD    = 1'($urandom);
    MEMWRITE   = 1'($urandom);
    ADDRESS    = {$urandom, $urandom};
    WRITE_DATA = {$urandom, $urandom};
  endtask

  // Updates the model for one accepted request; returns expected error and latency.
  task automatic model_apply(input bit rd, input bit wr, input logic [63:0] addr,
                             input logic [63:0] wdata, output bit err,
                             output int unsigned exp_lat);
    bit hit;
    err = is_err(rd, wr, addr);
    hit = tag_v && rd && !wr && !err && (addr == tag_addr);
`ifdef LEGV8_DMEM_FWD_EN
    exp_lat = hit ? 1 : WAITC + 1;
`else
    exp_lat = WAITC + 1;
`endif
    tag_v = 1'b0;
    if (err) begin
      exp_rd = '0;
    end else if (wr) begin
      model_mem[int'((addr - BASE) / 8)] = wdata;
      tag_v      = 1'b1;
      tag_addr   = addr;
      last_store = addr;
    end else begin
      exp_rd = model_mem[int'((addr - BASE) / 8)];
    end
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [63:0] addr,
                       input logic [63:0] wdata);
    @(negedge CLOCK);
    MEMREAD    = rd;
    MEMWRITE   = wr;
    ADDRESS    = addr;
    WRITE_DATA = wdata;
    @(posedge CLOCK);
    #1 garbage_inputs();
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [63:0] addr,
                     input logic [63:0] wdata);
    bit          err;
    int unsigned exp_lat, lat;
    model_apply(rd, wr, addr, wdata, err, exp_lat);
    issue(rd, wr, addr, wdata);
    @(negedge CLOCK);
    chk("busy_after_accept", 64'(MEM_BUSY), 64'd1);
    lat = 0;
    while (!MEM_READY && lat < LIMIT) begin
      @(negedge CLOCK);
      lat++;
    end
    idle_inputs();
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("error", 64'(MEM_ERROR), 64'(err));
    chk("read_data", READ_DATA, exp_rd);
    @(negedge CLOCK);
    chk("ready_pulse", 64'(MEM_READY), 64'd0);
    chk("error_clear", 64'(MEM_ERROR), 64'd0);
    chk("busy_clear", 64'(MEM_BUSY), 64'd0);
    chk("read_hold", READ_DATA, exp_rd);
  endtask

  initial begin
    int unsigned lat;
    bit          err;
    int unsigned exp_lat;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    exp_rd     = '0;
    tag_v      = 1'b0;
    tag_addr   = '0;
    last_store = 64'h10;
    idle_inputs();

    RESET = 1'b1;
    repeat (2) @(negedge CLOCK);
    chk("rst_read_data", READ_DATA, 64'd0);
    chk("rst_ready", 64'(MEM_READY), 64'd0);
    chk("rst_error", 64'(MEM_ERROR), 64'd0);
    chk("rst_busy", 64'(MEM_BUSY), 64'd0);
    RESET = 1'b0;

    txn(1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
    txn(1'b1, 1'b0, 64'h10, 64'h0);
    txn(1'b1, 1'b0, 64'h13, 64'h0);
    txn(1'b1, 1'b0, BASE + 64'(DEPTH) * 64'd8, 64'h0);
    txn(1'b1, 1'b0, 64'h10, 64'h0);
    txn(1'b1, 1'b1, 64'h20, 64'hFFFF_0000_FFFF_0000);
    txn(1'b1, 1'b0, 64'h20, 64'h0);

    // Reset while BUSY: the store never commits.
    issue(1'b0, 1'b1, 64'h28, 64'h1234);
    @(negedge CLOCK);
    chk("busy_before_reset", 64'(MEM_BUSY), 64'd1);
    RESET = 1'b1;
    #1;
    chk("reset_busy_drop", 64'(MEM_BUSY), 64'd0);
    chk("reset_ready_low", 64'(MEM_READY), 64'd0);
    @(negedge CLOCK);
    RESET = 1'b0;
    idle_inputs();
    tag_v  = 1'b0;
    exp_rd = '0;
    chk("reset_read_data", READ_DATA, 64'd0);
    txn(1'b1, 1'b0, 64'h28, 64'h0);

    txn(1'b0, 1'b1, 64'h30, 64'h55);
    txn(1'b1, 1'b0, 64'h30, 64'h0);

    // Reset during RESP: the store has already committed at RESP entry.
    model_apply(1'b0, 1'b1, 64'h40, 64'hA5A5_0000_1111_2222, err, exp_lat);
    issue(1'b0, 1'b1, 64'h40, 64'hA5A5_0000_1111_2222);
    lat = 0;
    while (!MEM_READY && lat < LIMIT) begin
      @(negedge CLOCK);
      lat++;
    end
    chk("resp_reached", 64'(MEM_READY), 64'd1);
    RESET = 1'b1;
    #1;
    chk("reset_resp_ready_drop", 64'(MEM_READY), 64'd0);
    chk("reset_resp_busy_drop", 64'(MEM_BUSY), 64'd0);
    @(negedge CLOCK);
    RESET = 1'b0;
    idle_inputs();
    tag_v  = 1'b0;
    exp_rd = '0;
    txn(1'b1, 1'b0, 64'h40, 64'h0);

    for (int n = 0; n < 80; n++) begin
      int unsigned kind, opk;
      logic [63:0] a, d;
      bit          rd, wr;
      kind = $urandom_range(0, 9);
      opk  = $urandom_range(0, 9);
      case (kind)
        0:       a = BASE + 64'($urandom_range(0, 255)) * 64'd8 + 64'($urandom_range(1, 7));
        1:       a = BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 31)) * 64'd8;
        2, 3:    a = last_store;
        default: a = BASE + 64'($urandom_range(0, 15)) * 64'd8;
      endcase
      rd = (opk == 0) || (opk >= 5);
      wr = (opk <= 4);
      d  = {$urandom, $urandom};
      txn(rd, wr, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
